// File: rtl/memory_access_unit.sv
// memory_access_unit: load/store controller for a word-addressed memory port.
// Takes one byte/half/word request at a time and returns a one-cycle response.
// Sub-word stores are done as read-modify-write, and loads are sign- or
// zero-extended.
module memory_access_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respError,
  output logic [31:0] memAddress,
  output logic        memReadEnable,
  output logic        memWriteEnable,
  output logic [31:0] memDataIn,
  input  logic [31:0] memDataOut
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_off;
  logic [15:0] lat_wdata;

  // Size 11 is illegal; halves need even addresses and words need addresses aligned to 4.
  function automatic logic is_err(input logic [1:0] size, input logic [1:0] off);
    logic e;
    case (size)
      2'b00:   e = 1'b0;
      2'b01:   e = off[0];
      2'b10:   e = (off != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Pull the addressed lane out of the word and extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overwrite the addressed byte/half lane of the old word with store data.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                        input logic [1:0] off, input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) begin
      case (off)
        2'b00:   r[7:0]   = wd[7:0];
        2'b01:   r[15:8]  = wd[7:0];
        2'b10:   r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  // Control FSM with all port outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      lat_write      <= 1'b0;
      lat_size       <= 2'b00;
      lat_signed     <= 1'b0;
      lat_off        <= 2'b00;
      lat_wdata      <= 16'd0;
      reqReady       <= 1'b1;
      respValid      <= 1'b0;
      respData       <= 32'd0;
      respError      <= 1'b0;
      memAddress     <= 32'd0;
      memReadEnable  <= 1'b0;
      memWriteEnable <= 1'b0;
      memDataIn      <= 32'd0;
    end else begin
      respValid <= 1'b0;
      respData  <= 32'd0;
      respError <= 1'b0;
      case (state)
        IDLE: begin
          if (reqValid) begin
            lat_write  <= reqWrite;
            lat_size   <= reqSize;
            lat_signed <= reqSigned;
            lat_off    <= reqAddr[1:0];
            lat_wdata  <= reqWdata[15:0];
            reqReady   <= 1'b0;
            if (is_err(reqSize, reqAddr[1:0])) begin
              // Bad request: answer straight away without touching memory.
              state     <= RESP;
              respValid <= 1'b1;
              respError <= 1'b1;
            end else if (!reqWrite || reqSize != 2'b10) begin
              // Loads and sub-word stores both need the current word first.
              state         <= READ;
              cnt           <= CNT_INIT;
              memReadEnable <= 1'b1;
              memAddress    <= {2'b00, reqAddr[31:2]};
            end else begin
              // Full-word stores need no read.
              state          <= WRITE;
              memWriteEnable <= 1'b1;
              memAddress     <= {2'b00, reqAddr[31:2]};
              memDataIn      <= reqWdata;
            end
          end
        end
        READ: begin
          if (cnt == 4'd0) begin
            memReadEnable <= 1'b0;
            if (lat_write) begin
              // Keep the address for the write-back of the merged word.
              state          <= WRITE;
              memWriteEnable <= 1'b1;
              memDataIn      <= merge(memDataOut, lat_size, lat_off, lat_wdata);
            end else begin
              state      <= RESP;
              memAddress <= 32'd0;
              respValid  <= 1'b1;
              respData   <= extract(memDataOut, lat_size, lat_off, lat_signed);
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WRITE: begin
          state          <= RESP;
          memWriteEnable <= 1'b0;
          memAddress     <= 32'd0;
          memDataIn      <= 32'd0;
          respValid      <= 1'b1;
        end
        default: begin
          // RESP: the response pulse ends here and the unit reopens.
          state    <= IDLE;
          reqReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed testbench for memory_access_unit with a small word memory model.
module tb_memory_access_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid, reqReady, reqWrite, reqSigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic        respValid, respError;
  logic [31:0] respData;
  logic [31:0] memAddress, memDataIn, memDataOut;
  logic        memReadEnable, memWriteEnable;

  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_addr = 6'd0;
  logic [31:0] pre_data = 32'd0;
  int          overlap = 0;

  int total = 0;
  int bad = 0;

  int          lat, rd_seen, wr_seen, rdy_seen, done;
  logic [31:0] got_data, wr_data, wr_addr;
  logic        got_err;

  memory_access_unit #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqWdata(reqWdata),
    .respValid(respValid), .respData(respData), .respError(respError),
    .memAddress(memAddress), .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable),
    .memDataIn(memDataIn), .memDataOut(memDataOut)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  assign memDataOut = mem[memAddress[5:0]];

  always @(posedge clk) begin
    if (memWriteEnable) mem[memAddress[5:0]] <= memDataIn;
    else if (pre_we)    mem[pre_addr] <= pre_data;
  end

  always @(negedge clk) begin
    if (memReadEnable && memWriteEnable) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one request from a falling edge and observe until its response.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqWdata = wd;
    reqValid = 1'b1;
    @(posedge clk);
    #1 reqValid = 1'b0;
    lat = 0; rd_seen = 0; wr_seen = 0; rdy_seen = 0; done = 0;
    got_data = 32'd0; got_err = 1'b0; wr_data = 32'd0; wr_addr = 32'd0;
    for (int k = 1; k <= 40 && done == 0; k++) begin
      @(negedge clk);
      if (memReadEnable) rd_seen++;
      if (memWriteEnable) begin
        wr_seen++; wr_data = memDataIn; wr_addr = memAddress;
      end
      if (reqReady) rdy_seen++;
      if (respValid) begin
        done = 1; lat = k; got_data = respData; got_err = respError;
      end
    end
    check("resp_seen", done, 1);
    @(negedge clk);
    check("idle_after_resp", {30'd0, respValid, reqReady}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00; reqSigned = 1'b0;
    reqAddr = 32'd0; reqWdata = 32'd0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);

    check("rst_reqReady", reqReady, 1);
    check("rst_respValid", respValid, 0);
    check("rst_respData", respData, 0);
    check("rst_respError", respError, 0);
    check("rst_memRead", memReadEnable, 0);
    check("rst_memWrite", memWriteEnable, 0);
    check("rst_memAddress", memAddress, 0);
    check("rst_memDataIn", memDataIn, 0);

    rst_n = 1'b1;
    preload(6'd4, 32'h8899AABB);
    @(negedge clk);

    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'd0);
    check("lb_signed_data", got_data, 32'hFFFFFFAA);
    check("lb_signed_err", got_err, 0);
    check("lb_latency", lat, LAT + 1);
    check("lb_reads", rd_seen, LAT);

    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
    check("lhu_data", got_data, 32'h00008899);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'd0);
    check("lh_signed_data", got_data, 32'hFFFFAABB);
    do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'd0);
    check("lw_data", got_data, 32'h8899AABB);

    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000005C);
    check("sb_latency", lat, LAT + 2);
    check("sb_reads", rd_seen, LAT);
    check("sb_writes", wr_seen, 1);
    check("sb_wdata", wr_data, 32'h5C99AABB);
    check("sb_waddr", wr_addr, 32'h4);
    check("sb_resp_data", got_data, 0);
    check("sb_mem", mem[4], 32'h5C99AABB);

    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
    check("lbu_after_sb", got_data, 32'h0000005C);

    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234);
    check("sh_wdata", wr_data, 32'h1234AABB);
    check("sh_mem", mem[4], 32'h1234AABB);

    do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h01020304);
    check("sw_mis_err", got_err, 1);
    check("sw_mis_latency", lat, 1);
    check("sw_mis_data", got_data, 0);
    check("sw_mis_strobes", rd_seen + wr_seen, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h01, 32'd0);
    check("lh_mis_err", got_err, 1);
    check("lh_mis_latency", lat, 1);
    check("lh_mis_strobes", rd_seen + wr_seen, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    check("size11_err", got_err, 1);

    do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    check("sw_latency", lat, 2);
    check("sw_ready_low", rdy_seen, 0);
    check("sw_mem", mem[16], 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'd0);
    check("b2b_lw_data", got_data, 32'hDEADBEEF);
    check("b2b_lw_ready_low", rdy_seen, 0);
    check("b2b_lw_latency", lat, LAT + 1);

    // Reset in the middle of a read-modify-write.
    preload(6'd8, 32'h11223344);
    @(negedge clk);
    reqWrite = 1'b1; reqSize = 2'b00; reqSigned = 1'b0; reqAddr = 32'h20; reqWdata = 32'hEE;
    reqValid = 1'b1;
    @(posedge clk);
    #1 reqValid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_read", memReadEnable, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rd_drop", memReadEnable, 0);
    check("rst_mid_wr_drop", memWriteEnable, 0);
    check("rst_mid_addr", memAddress, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_seen = 0; done = 0;
    repeat (6) begin
      @(negedge clk);
      if (memWriteEnable) wr_seen++;
      if (respValid) done++;
    end
    check("rst_mid_no_write", wr_seen, 0);
    check("rst_mid_no_resp", done, 0);
    check("rst_mid_ready", reqReady, 1);
    check("rst_mid_mem", mem[8], 32'h11223344);

    check("no_strobe_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
